// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
//
// Receives a byte stream over a valid/ready handshake:
//   count_lo, count_hi            16-bit word count N, little-endian
//   N x 4 payload bytes           each word little-endian, first byte -> [7:0]
//   1 checksum byte               XOR of all payload bytes (header excluded)
// Words are written to consecutive word addresses starting at 0. The core is
// held in reset until an image with a good checksum has been loaded.
//
// Handshake: a byte transfers on a rising edge where i_rxValid && o_rxReady.
// o_rxReady depends only on state and i_srst, never on i_rxValid, so the
// loader never back-pressures while it is receiving; the sender may drop
// i_rxValid at any time and all partial state is held.
//
// Ports:
//   i_clk, i_srst         clock, synchronous active-high reset
//   i_rxData/i_rxValid    stream byte and its valid
//   o_rxReady             loader can take a byte (combinational)
//   i_restart             reload request, honoured in DONE or ERROR only
//   o_memWrite*           one-cycle write strobe, word address, word data
//   o_coreSrst            core reset, low only after a good image
//   o_done / o_error      image accepted / rejected
//   o_dbgState            current FSM state encoding, for observation
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic [7:0]        i_rxData,
  input  logic              i_rxValid,
  output logic              o_rxReady,
  input  logic              i_restart,
  output logic              o_memWriteEnable,
  output logic [ADDR_W-1:0] o_memWriteAddress,
  output logic [31:0]       o_memWriteData,
  output logic              o_coreSrst,
  output logic              o_done,
  output logic              o_error,
  output logic [2:0]        o_dbgState
);

  typedef enum logic [2:0] {
    S_HDR_LO  = 3'd0,
    S_HDR_HI  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_e;

  // Largest legal word count, 2**ADDR_W, held in 17 bits so it can be
  // compared against a 16-bit count without overflow.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;   // count_lo, then the full N
  logic [ADDR_W:0]     idx_q, idx_d;       // one extra bit: N == 2**ADDR_W
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         shift_q, shift_d;
  logic [7:0]          xor_q, xor_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                core_srst_q, core_srst_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                rx_ready;
  logic                xfer;
  logic [15:0]         n_full;
  logic [ADDR_W:0]     idx_inc;

  always_comb begin
    rx_ready = ((state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                (state_q == S_PAYLOAD) || (state_q == S_CHECK)) && !i_srst;
    xfer     = i_rxValid && rx_ready;
    n_full   = {i_rxData, count_q[7:0]};
    idx_inc  = idx_q + 1'b1;

    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    xor_d       = xor_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    core_srst_d = core_srst_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_HDR_LO: begin
        if (xfer) begin
          count_d = {8'h00, i_rxData};
          state_d = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (xfer) begin
          count_d = n_full;
          if ({1'b0, n_full} > CAP) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (n_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          xor_d   = xor_q ^ i_rxData;
          bcnt_d  = bcnt_q + 2'd1;
          // Bytes enter at the top so the first byte of a word ends at [7:0].
          shift_d = {i_rxData, shift_q[23:8]};
          if (bcnt_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = idx_q[ADDR_W-1:0];
            data_d = {i_rxData, shift_q};
            idx_d  = idx_inc;
            if (17'(idx_inc) == {1'b0, count_q}) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (i_rxData == xor_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            core_srst_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (i_restart) begin
          state_d     = S_HDR_LO;
          done_d      = 1'b0;
          error_d     = 1'b0;
          core_srst_d = 1'b1;
          xor_d       = 8'h00;
          idx_d       = '0;
          bcnt_d      = 2'd0;
        end
      end
      default: begin
        state_d = S_HDR_LO;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q     <= S_HDR_LO;
      count_q     <= 16'h0000;
      idx_q       <= '0;
      bcnt_q      <= 2'd0;
      shift_q     <= 24'h000000;
      xor_q       <= 8'h00;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= 32'h0;
      core_srst_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      xor_q       <= xor_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      core_srst_q <= core_srst_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign o_rxReady         = rx_ready;
  assign o_memWriteEnable  = we_q;
  assign o_memWriteAddress = addr_q;
  assign o_memWriteData    = data_q;
  assign o_coreSrst        = core_srst_q;
  assign o_done            = done_q;
  assign o_error           = error_q;
  assign o_dbgState        = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// The DUT is built with ADDR_W=4 (capacity 16 words) so the capacity limit
// and the full-capacity image are both reachable with short streams.
// Expected writes and the final verdict are derived from the byte stream
// itself: header -> N, payload grouped in fours -> words, XOR of payload.
module tb_imem_loader;

  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  logic          i_clk;
  logic          i_srst;
  logic [7:0]    i_rxData;
  logic          i_rxValid;
  logic          o_rxReady;
  logic          i_restart;
  logic          o_memWriteEnable;
  logic [AW-1:0] o_memWriteAddress;
  logic [31:0]   o_memWriteData;
  logic          o_coreSrst;
  logic          o_done;
  logic          o_error;
  logic [2:0]    o_dbgState;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  logic [7:0] img_q[$];

  imem_loader #(.ADDR_W(AW)) dut (
    .i_clk             (i_clk),
    .i_srst            (i_srst),
    .i_rxData          (i_rxData),
    .i_rxValid         (i_rxValid),
    .o_rxReady         (o_rxReady),
    .i_restart         (i_restart),
    .o_memWriteEnable  (o_memWriteEnable),
    .o_memWriteAddress (o_memWriteAddress),
    .o_memWriteData    (o_memWriteData),
    .o_coreSrst        (o_coreSrst),
    .o_done            (o_done),
    .o_error           (o_error),
    .o_dbgState        (o_dbgState)
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Every write strobe, whenever it happens.
  always @(negedge i_clk) begin
    if (o_memWriteEnable === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Optional idle gap (with stray i_restart pulses that must be ignored),
  // then present one byte and hold it until it is accepted. Returns at the
  // falling edge after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int k;
    repeat ($urandom_range(0, gap_max)) begin
      i_rxValid = 1'b0;
      i_restart = ($urandom_range(0, 3) == 0);
      @(negedge i_clk);
    end
    i_restart = 1'b0;
    i_rxData  = b;
    i_rxValid = 1'b1;
    #1;
    k = 0;
    while (o_rxReady !== 1'b1 && k < 20) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    if (o_rxReady !== 1'b1) begin
      check("rx_ready_timeout", {31'b0, o_rxReady}, 32'd1);
      i_rxValid = 1'b0;
      return;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_rxValid = 1'b0;
  endtask

  task automatic do_restart();
    i_restart = 1'b1;
    @(negedge i_clk);
    i_restart = 1'b0;
    check("restart_core_srst", {31'b0, o_coreSrst}, 32'd1);
    check("restart_done",      {31'b0, o_done},     32'd0);
    check("restart_error",     {31'b0, o_error},    32'd0);
    check("restart_rx_ready",  {31'b0, o_rxReady},  32'd1);
  endtask

  // Drive img_q and check it against the stream-level model.
  task automatic run_image(input int gap_max);
    int          n, nacc, base, pos;
    bit          over, good, exp_we;
    logic [7:0]  cs;
    logic [31:0] exp_w;
    n    = int'({img_q[1], img_q[0]});
    over = (n > CAP);
    nacc = over ? 2 : 2 + 4 * n + 1;
    cs   = 8'h00;
    if (!over) for (int i = 2; i < 2 + 4 * n; i++) cs ^= img_q[i];
    good = !over && (img_q[nacc-1] == cs);
    base = wr_cnt;
    for (int i = 0; i < nacc; i++) begin
      if (i == nacc - 1) check("core_srst_held", {31'b0, o_coreSrst}, 32'd1);
      send_byte(img_q[i], gap_max);
      pos    = i - 2;
      exp_we = !over && pos >= 0 && pos < 4 * n && (pos % 4) == 3;
      check("we", {31'b0, o_memWriteEnable}, {31'b0, exp_we});
      if (exp_we) begin
        exp_w = {img_q[i], img_q[i-1], img_q[i-2], img_q[i-3]};
        check("waddr", {28'b0, o_memWriteAddress}, 32'(pos / 4));
        check("wdata", o_memWriteData, exp_w);
      end
    end
    check("done",      {31'b0, o_done},     {31'b0, good});
    check("error",     {31'b0, o_error},    {31'b0, !good});
    check("core_srst", {31'b0, o_coreSrst}, {31'b0, !good});
    check("rx_ready_end", {31'b0, o_rxReady}, 32'd0);
    check("write_count", 32'(wr_cnt - base), over ? 32'd0 : 32'(n));
  endtask

  task automatic load_spec_image(input logic [7:0] csum);
    img_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
              8'h13, 8'h01, 8'hA0, 8'h00, csum};
  endtask

  task automatic build_random(input int n, input bit corrupt);
    logic [7:0] cs;
    cs = 8'h00;
    img_q = {};
    img_q.push_back(n[7:0]);
    img_q.push_back(n[15:8]);
    if (n <= CAP) begin
      for (int i = 0; i < 4 * n; i++) begin
        img_q.push_back(8'($urandom));
        cs ^= img_q[img_q.size() - 1];
      end
      img_q.push_back(corrupt ? (cs ^ 8'(1 + $urandom_range(0, 254))) : cs);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_srst    = 1'b1;
    i_rxData  = 8'h00;
    i_rxValid = 1'b0;
    i_restart = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_we",        {31'b0, o_memWriteEnable}, 32'd0);
    check("rst_addr",      {28'b0, o_memWriteAddress}, 32'd0);
    check("rst_data",      o_memWriteData, 32'd0);
    check("rst_done",      {31'b0, o_done},     32'd0);
    check("rst_error",     {31'b0, o_error},    32'd0);
    check("rst_core_srst", {31'b0, o_coreSrst}, 32'd1);
    check("rst_rx_ready",  {31'b0, o_rxReady},  32'd0);
    i_srst = 1'b0;
    #1;
    check("post_rst_rx_ready", {31'b0, o_rxReady}, 32'd1);
    @(negedge i_clk);

    // Good two-word image at full rate.
    load_spec_image(8'h71);
    run_image(0);
    do_restart();

    // Same image, wrong checksum: writes stay, core stays in reset.
    load_spec_image(8'h70);
    run_image(0);
    do_restart();

    // Empty image.
    img_q = '{8'h00, 8'h00, 8'h00};
    run_image(0);
    do_restart();

    // One word over capacity: rejected on count_hi.
    img_q = '{8'h11, 8'h00};
    run_image(0);
    do_restart();

    // Exactly full capacity.
    build_random(CAP, 1'b0);
    run_image(2);
    do_restart();

    // Reset in the middle of a word discards the partial load.
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    i_srst = 1'b1;
    @(negedge i_clk);
    check("mid_rst_rx_ready",  {31'b0, o_rxReady},  32'd0);
    check("mid_rst_core_srst", {31'b0, o_coreSrst}, 32'd1);
    check("mid_rst_state",     {29'b0, o_dbgState}, 32'd0);
    i_srst = 1'b0;
    load_spec_image(8'h71);
    run_image(3);

    // Restart from DONE and load a one-word image.
    do_restart();
    img_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    run_image(1);

    // Randomized images: sizes across and beyond capacity, good/bad sums.
    for (int t = 0; t < 10; t++) begin
      do_restart();
      build_random($urandom_range(0, CAP + 4), $urandom_range(0, 1) == 1);
      run_image($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
